// File: rtl/hd_dma_arbiter_if.sv
// Bus bundle for the HD/IM DMA arbiter: CPU request port, DMA control,
// IM write port and HD memory port.
interface hd_dma_arbiter_if #(
   parameter int HD_AW = 12,
   parameter int IM_AW = 10,
   parameter int DW    = 32
);
   logic             cpu_req;
   logic             cpu_we;
   logic [HD_AW-1:0] cpu_addr;
   logic [DW-1:0]    cpu_wdata;
   logic [DW-1:0]    cpu_rdata;
   logic             cpu_ack;

   logic             dma_start;
   logic [HD_AW-1:0] dma_src;
   logic [IM_AW-1:0] dma_dst;
   logic [IM_AW-1:0] dma_len;
   logic             dma_busy;
   logic             dma_done;

   logic             im_we;
   logic [IM_AW-1:0] im_addr;
   logic [DW-1:0]    im_wdata;

   logic [HD_AW-1:0] HDaddress;
   logic [DW-1:0]    HDoutdata;
   logic             HDwe;
   logic [DW-1:0]    HDIndata;

   // requester / memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_start, dma_src, dma_dst, dma_len,
      output HDIndata,
      input  cpu_rdata, cpu_ack, dma_busy, dma_done,
      input  im_we, im_addr, im_wdata,
      input  HDaddress, HDoutdata, HDwe
   );

   // arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_start, dma_src, dma_dst, dma_len,
      input  HDIndata,
      output cpu_rdata, cpu_ack, dma_busy, dma_done,
      output im_we, im_addr, im_wdata,
      output HDaddress, HDoutdata, HDwe
   );
endinterface

// File: rtl/hd_dma_arbiter.sv
// Shares the single HD memory port between CPU accesses and an HD-to-IM
// block-copy engine, with 1-bit round-robin arbitration.
//
// state    | meaning
// IDLE     | arbitrate; latch the granted request onto the HD port
// CPU_ACC  | HD port carries the CPU address / write strobe
// CPU_DATA | HD read data returns; captured into cpu_rdata
// DMA_ACC  | HD port carries src+i (read)
// DMA_DATA | HD read data forwarded to IM at dst+i
module hd_dma_arbiter #(
   parameter int HD_AW = 12,
   parameter int IM_AW = 10,
   parameter int DW    = 32
) (
   input logic               clock,
   input logic               resetCPU,
   hd_dma_arbiter_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      CPU_ACC,
      CPU_DATA,
      DMA_ACC,
      DMA_DATA
   } state_t;

   localparam logic [IM_AW-1:0] ONE_IM = 1;

   state_t           state;
   state_t           state_nxt;
   logic [HD_AW-1:0] src_q;
   logic [IM_AW-1:0] dst_q;
   logic [IM_AW-1:0] len_q;
   logic [IM_AW-1:0] idx_q;
   logic [IM_AW-1:0] idx_inc;
   logic             we_q;
   logic             favour_dma;
   logic             cpu_pend;
   logic             dma_pend;
   logic             grant_cpu;
   logic             grant_dma;
   logic             last_word;
   logic [DW-1:0]    hd_q;

   assign hd_q      = bus.HDIndata;
   assign idx_inc   = idx_q + ONE_IM;
   assign last_word = (idx_inc == len_q);

   always_comb begin
      state_nxt    = state;
      grant_cpu    = 1'b0;
      grant_dma    = 1'b0;
      bus.im_we    = 1'b0;
      bus.im_addr  = '0;
      bus.im_wdata = '0;
      // an acked request is complete even if cpu_req is still high
      cpu_pend     = bus.cpu_req && !bus.cpu_ack;
      dma_pend     = bus.dma_busy;

      case (state)
         IDLE: begin
            if (cpu_pend && (!dma_pend || !favour_dma)) begin
               grant_cpu = 1'b1;
               state_nxt = CPU_ACC;
            end else if (dma_pend) begin
               grant_dma = 1'b1;
               state_nxt = DMA_ACC;
            end
         end
         CPU_ACC:  state_nxt = CPU_DATA;
         CPU_DATA: state_nxt = IDLE;
         DMA_ACC:  state_nxt = DMA_DATA;
         DMA_DATA: begin
            bus.im_we    = 1'b1;
            bus.im_addr  = dst_q + idx_q;
            bus.im_wdata = hd_q;
            state_nxt    = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetCPU) begin
         state         <= IDLE;
         favour_dma    <= 1'b0;
         we_q          <= 1'b0;
         src_q         <= '0;
         dst_q         <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         bus.cpu_rdata <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.dma_busy  <= 1'b0;
         bus.dma_done  <= 1'b0;
         bus.HDaddress <= '0;
         bus.HDoutdata <= '0;
         bus.HDwe      <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus.cpu_ack  <= 1'b0;
         bus.dma_done <= 1'b0;
         bus.HDwe     <= 1'b0;

         if (grant_cpu) begin
            bus.HDaddress <= bus.cpu_addr;
            bus.HDoutdata <= bus.cpu_wdata;
            bus.HDwe      <= bus.cpu_we;
            we_q          <= bus.cpu_we;
            favour_dma    <= 1'b1;
         end

         if (grant_dma) begin
            bus.HDaddress <= src_q + HD_AW'(idx_q);
            favour_dma    <= 1'b0;
         end

         if (state == CPU_DATA) begin
            bus.cpu_ack <= 1'b1;
            if (!we_q) bus.cpu_rdata <= hd_q;
         end

         if (state == DMA_DATA) begin
            idx_q <= idx_inc;
            if (last_word) begin
               bus.dma_busy <= 1'b0;
               bus.dma_done <= 1'b1;
            end
         end

         // busy is clear on the completion cycle, so a restart is taken there
         if (bus.dma_start && !bus.dma_busy) begin
            if (bus.dma_len != '0) begin
               src_q        <= bus.dma_src;
               dst_q        <= bus.dma_dst;
               len_q        <= bus.dma_len;
               idx_q        <= '0;
               bus.dma_busy <= 1'b1;
            end else begin
               bus.dma_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/hd_dma_arbiter.md
HD_DMA_ARBITER -- requirements
Module: hd_dma_arbiter

Interface
REQ-001 Parameter HD_AW, 12: HD word-address width.
REQ-002 Parameter IM_AW, 10: instruction-memory word-address width.
REQ-003 Parameter DW, 32: data width.
REQ-004 clock  in  1  system clock; all logic is on the rising edge.
REQ-005 resetCPU  in  1  reset, synchronous and active-low.
REQ-006 cpu_req  in  1  CPU requests an HD access; held with its inputs until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  HD_AW  CPU HD address.
REQ-009 cpu_wdata  in  DW  CPU write data.
REQ-010 cpu_rdata  out  DW  read data; valid while cpu_ack=1; held until the next CPU read completes.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 dma_start  in  1  one-cycle pulse that starts an HD-to-IM block copy.
REQ-013 dma_src  in  HD_AW  HD base address, sampled on start.
REQ-014 dma_dst  in  IM_AW  IM base address, sampled on start.
REQ-015 dma_len  in  IM_AW  word count, sampled on start.
REQ-016 dma_busy  out  1  copy in progress.
REQ-017 dma_done  out  1  one-cycle completion pulse.
REQ-018 im_we, im_addr, im_wdata  out  1/IM_AW/DW  IM write port.
REQ-019 HDaddress, HDoutdata, HDwe  out  HD_AW/DW/1  HD port.
REQ-020 HDIndata  in  DW  HD q; valid one cycle after the address is presented.

Function
REQ-021 The FSM SHALL have these states: IDLE, CPU_ACC, CPU_DATA, DMA_ACC, DMA_DATA.
REQ-022 Requests:
- CPU is pending when cpu_req=1 and cpu_ack=0.
- DMA is pending when dma_busy=1 and words remain.
REQ-023 Arbitration in IDLE:
- One pending requester SHALL be granted.
- If both are pending, the requester not granted last SHALL be granted (1-bit round-robin; after reset the CPU is favoured).
REQ-024 CPU grant at cycle T:
- IDLE latches addr/we/wdata and goes to CPU_ACC.
- CPU_ACC (T+1) drives the HD port with the latched values; HDwe=cpu_we for exactly that cycle.
- CPU_DATA (T+2) registers HDIndata into cpu_rdata (reads only) and returns to IDLE.
- cpu_ack=1 at T+3.
REQ-025 CPU write: HDwe=1 only in CPU_ACC; cpu_rdata is unchanged.
REQ-026 DMA grant for word i:
- DMA_ACC drives HDaddress=src+i and HDwe=0.
- DMA_DATA drives im_we=1, im_addr=dst+i, im_wdata=HDIndata, increments i, then returns to IDLE.
REQ-027 Address arithmetic: src+i SHALL wrap modulo 2^HD_AW and dst+i modulo 2^IM_AW.
REQ-028 Start handling:
- dma_start with dma_busy=0 and dma_len>0 latches src, dst and len, clears i, and sets dma_busy the next cycle.
- dma_start while dma_busy=1 SHALL be ignored.
REQ-029 dma_len=0 SHALL give dma_done=1 for one cycle, one cycle after start; dma_busy stays 0 and no HD or IM access occurs.
REQ-030 Completion: the cycle after DMA_DATA of the last word, dma_done=1 for one cycle and dma_busy=0. A new start is accepted in that same cycle.
REQ-031 Default outputs:
- HDwe=0 and im_we=0 outside their defined states.
- HDaddress and HDoutdata hold their last value.
REQ-032 DMA SHALL never write HD; CPU SHALL never write IM.
REQ-033 When CPU and DMA are both continuously pending, grants SHALL alternate strictly CPU, DMA, CPU, DMA, ...

Reset
REQ-034 While resetCPU=0 at a clock edge:
- state=IDLE; all outputs 0 (cpu_rdata=0, HDaddress=0, HDoutdata=0).
- i=0; round-robin favours the CPU.
REQ-035 Reset during a DMA SHALL abort it with no dma_done pulse.
REQ-036 Reset during CPU_ACC or CPU_DATA SHALL abort that access with no cpu_ack; the CPU re-requests after reset.

Verification
REQ-037 CPU read: HD[0x123]=0xDEADBEEF, cpu_req with addr 0x123 at T -> HDaddress=0x123 at T+1; cpu_ack=1 and cpu_rdata=0xDEADBEEF at T+3, one cycle only.
REQ-038 CPU write: addr 0x010, data 0x0000ABCD -> HDwe=1 for exactly one cycle with HDaddress=0x010; a later read of 0x010 returns 0x0000ABCD.
REQ-039 DMA copy: src 0x200, dst 0x000, len 4, HD[0x200..0x203]=1,2,3,4 -> four im_we pulses (addr 0..3, data 1..4), dma_done once, dma_busy low afterwards.
REQ-040 Contention: CPU holds back-to-back reads during DMA len 3 -> grants alternate CPU, DMA, ...; every CPU read returns correct data; DMA completes.
REQ-041 Boundaries:
- src 0xFFE, dst 0x3FF, len 3 -> HD 0xFFE, 0xFFF, 0x000 copied to IM 0x3FF, 0x000, 0x001.
- len=0 -> dma_done one cycle after start, no im_we.
- start while busy -> ignored.
REQ-042 Reset mid-DMA: resetCPU=0 after 2 of 8 words -> dma_busy=0, no dma_done; a new start then runs normally.
